// File: rtl/fa_pkg.sv
// Shared widths and line layout for the fully associative cache.
// Optional FA_PERF_CNT_EN adds hit/miss counters on the top.
package fa_pkg;

  localparam int WIDTH    = 32;
  localparam int C        = 16;
  localparam int B        = 4;
  localparam int A        = C / B;
  localparam int OFFSET_W = $clog2(B);
  localparam int TAG_W    = WIDTH - OFFSET_W;
  localparam int AGE_W    = $clog2(A);

  typedef logic [AGE_W-1:0] age_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [WIDTH-1:0] word_t;

  typedef struct packed {
    logic  valid;
    logic  dirty;
    tag_t  tag;
    word_t data;
  } line_t;

endpackage

// File: rtl/fa_lru.sv
// True-LRU age array; age 0 is MRU, age A-1 is the replacement candidate.
module fa_lru
  import fa_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic touch_en,
  input  age_t touch_way,
  output age_t lru_way
);

  age_t age [A];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < A; i++)
        age[i] <= age_t'(i);
    end else if (touch_en) begin
      for (int i = 0; i < A; i++) begin
        if (age_t'(i) == touch_way)
          age[i] <= '0;
        else if (age[i] < age[touch_way])
          age[i] <= age[i] + 1'b1;
      end
    end
  end

  always_comb begin
    lru_way = '0;
    for (int i = 0; i < A; i++)
      if (age[i] == age_t'(A - 1))
        lru_way = age_t'(i);
  end

endmodule

// File: rtl/fully_associative.sv
// Fully associative write-allocate cache, one word per line, true LRU.
// Define FA_PERF_CNT_EN to add saturating hit/miss counters.
module fully_associative
  import fa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] address_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             wen_i,
  input  logic             ren_i,
`ifdef FA_PERF_CNT_EN
  output logic [31:0]      hit_cnt_o,
  output logic [31:0]      miss_cnt_o,
`endif
  output logic             hit_o,
  output logic [WIDTH-1:0] data_o
);

  line_t lines [A];
  tag_t  tag;
  logic  hit;
  age_t  hit_way;
  logic  free;
  age_t  free_way;
  age_t  lru_way;
  age_t  victim;
  logic  touch_en;
  age_t  touch_way;

  assign tag = address_i[WIDTH-1:OFFSET_W];

  // Reverse scan so the lowest-index match/free way wins.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    free     = 1'b0;
    free_way = '0;
    for (int i = A - 1; i >= 0; i--) begin
      if (lines[i].valid && lines[i].tag == tag) begin
        hit     = 1'b1;
        hit_way = age_t'(i);
      end
      if (!lines[i].valid) begin
        free     = 1'b1;
        free_way = age_t'(i);
      end
    end
  end

  assign victim    = free ? free_way : lru_way;
  assign touch_en  = wen_i | (ren_i & hit);
  assign touch_way = hit ? hit_way : victim;

  fa_lru u_lru (
    .clk       (clk),
    .rst       (rst),
    .touch_en  (touch_en),
    .touch_way (touch_way),
    .lru_way   (lru_way)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < A; i++) begin
        lines[i].valid <= 1'b0;
        lines[i].dirty <= 1'b0;
      end
      hit_o  <= 1'b0;
      data_o <= '0;
    end else if (wen_i) begin
      hit_o <= hit;
      if (hit) begin
        lines[hit_way].data  <= data_i;
        lines[hit_way].dirty <= 1'b1;
      end else begin
        lines[victim] <= '{valid: 1'b1, dirty: 1'b1,
                           tag: tag, data: data_i};
      end
    end else if (ren_i) begin
      hit_o  <= hit;
      data_o <= hit ? lines[hit_way].data : '0;
    end else begin
      hit_o <= 1'b0;
    end
  end

`ifdef FA_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (wen_i || ren_i) begin
      if (hit && hit_cnt_o != '1)
        hit_cnt_o <= hit_cnt_o + 1'b1;
      else if (!hit && miss_cnt_o != '1)
        miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end
`endif

  // Dirty bits and byte offset are kept for future memory-side logic.
  logic unused_bits;
  always_comb begin
    unused_bits = ^address_i[OFFSET_W-1:0];
    for (int i = 0; i < A; i++)
      unused_bits = unused_bits ^ lines[i].dirty;
  end

endmodule

// File: tb/tb_fully_associative.sv
// Directed self-checking bench for the fully associative cache.
module tb_fully_associative;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic        hit;
  logic [31:0] data_out;
`ifdef FA_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] BASE = 32'h0400_0000;

  fully_associative dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address),
    .data_i    (data_in),
    .wen_i     (wen),
    .ren_i     (ren),
`ifdef FA_PERF_CNT_EN
    .hit_cnt_o (hit_cnt),
    .miss_cnt_o(miss_cnt),
`endif
    .hit_o     (hit),
    .data_o    (data_out)
  );

  always #5 clk = ~clk;

  task automatic acc(input logic w, input logic r,
                     input logic [31:0] a, input logic [31:0] d);
    wen = w;
    ren = r;
    address = a;
    data_in = d;
    @(posedge clk);
    #1;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    checks++;
    if (hit !== 1'b0 || data_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: hit=%b data=%0d want hit=0 data=0",
               hit, data_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill;
    logic [31:0] v [4];
    v = '{32'd11, 32'd22, 32'd33, 32'd44};
    for (int i = 0; i < 4; i++) begin
      acc(1, 0, BASE + 32'(4 * i), v[i]);
      checks++;
      if (hit !== 1'b0 || data_out !== 32'h0) begin
        failures++;
        $display("FAIL fill_write[%0d]: hit=%b data=%0d want 0/0",
                 i, hit, data_out);
      end
    end
    for (int i = 0; i < 4; i++) begin
      acc(0, 1, BASE + 32'(4 * i), 32'h0);
      checks++;
      if (hit !== 1'b1 || data_out !== v[i]) begin
        failures++;
        $display("FAIL fill_read[%0d]: hit=%b data=%0d want 1/%0d",
                 i, hit, data_out, v[i]);
      end
    end
  endtask

  task automatic test_evict;
    logic [31:0] ea [5];
    logic        eh [5];
    logic [31:0] ed [5];
    ea = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, BASE + 32'h10};
    eh = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ed = '{32'd0, 32'd22, 32'd33, 32'd44, 32'd55};
    acc(1, 0, BASE + 32'h10, 32'd55);
    checks++;
    if (hit !== 1'b0) begin
      failures++;
      $display("FAIL evict_write: hit=%b want 0", hit);
    end
    for (int i = 0; i < 5; i++) begin
      acc(0, 1, ea[i], 32'h0);
      checks++;
      if (hit !== eh[i] || data_out !== ed[i]) begin
        failures++;
        $display("FAIL evict_read[%0d]: hit=%b data=%0d want %b/%0d",
                 i, hit, data_out, eh[i], ed[i]);
      end
    end
  endtask

  task automatic test_lru_order;
    logic [31:0] v [4];
    logic        eh [6];
    logic [31:0] ed [6];
    v  = '{32'd111, 32'd222, 32'd333, 32'd444};
    eh = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    ed = '{32'd111, 32'd0, 32'd333, 32'd0, 32'd555, 32'd666};
    apply_reset();
    for (int i = 0; i < 4; i++)
      acc(1, 0, BASE + 32'(4 * i), v[i]);
    acc(0, 1, BASE, 32'h0);
    checks++;
    if (hit !== 1'b1 || data_out !== 32'd111) begin
      failures++;
      $display("FAIL lru_touch0: hit=%b data=%0d want 1/111", hit, data_out);
    end
    acc(0, 1, BASE + 32'h8, 32'h0);
    checks++;
    if (hit !== 1'b1 || data_out !== 32'd333) begin
      failures++;
      $display("FAIL lru_touch8: hit=%b data=%0d want 1/333", hit, data_out);
    end
    acc(1, 0, BASE + 32'h10, 32'd555);
    acc(1, 0, BASE + 32'h14, 32'd666);
    for (int i = 0; i < 6; i++) begin
      acc(0, 1, BASE + 32'(4 * i), 32'h0);
      checks++;
      if (hit !== eh[i] || data_out !== ed[i]) begin
        failures++;
        $display("FAIL lru_read[%0d]: hit=%b data=%0d want %b/%0d",
                 i, hit, data_out, eh[i], ed[i]);
      end
    end
  endtask

  task automatic test_write_hit;
    apply_reset();
    acc(1, 0, BASE + 32'h20, 32'd1);
    acc(1, 0, BASE + 32'h24, 32'd2);
    acc(1, 0, BASE, 32'd7);
    checks++;
    if (hit !== 1'b0) begin
      failures++;
      $display("FAIL wr_first: hit=%b want 0", hit);
    end
    acc(1, 0, BASE, 32'd9);
    checks++;
    if (hit !== 1'b1) begin
      failures++;
      $display("FAIL wr_overwrite: hit=%b want 1", hit);
    end
    acc(0, 1, BASE + 32'h3, 32'h0);
    checks++;
    if (hit !== 1'b1 || data_out !== 32'd9) begin
      failures++;
      $display("FAIL wr_offset_read: hit=%b data=%0d want 1/9", hit, data_out);
    end
    acc(0, 1, BASE + 32'h20, 32'h0);
    checks++;
    if (hit !== 1'b1 || data_out !== 32'd1) begin
      failures++;
      $display("FAIL wr_other20: hit=%b data=%0d want 1/1", hit, data_out);
    end
    acc(0, 1, BASE + 32'h24, 32'h0);
    checks++;
    if (hit !== 1'b1 || data_out !== 32'd2) begin
      failures++;
      $display("FAIL wr_other24: hit=%b data=%0d want 1/2", hit, data_out);
    end
  endtask

  task automatic test_write_priority;
    acc(1, 1, BASE, 32'd5);
    checks++;
    if (hit !== 1'b1 || data_out !== 32'd2) begin
      failures++;
      $display("FAIL both_en: hit=%b data=%0d want 1/2", hit, data_out);
    end
    acc(0, 0, BASE, 32'h0);
    checks++;
    if (hit !== 1'b0 || data_out !== 32'd2) begin
      failures++;
      $display("FAIL idle: hit=%b data=%0d want 0/2", hit, data_out);
    end
    acc(0, 1, BASE, 32'h0);
    checks++;
    if (hit !== 1'b1 || data_out !== 32'd5) begin
      failures++;
      $display("FAIL both_readback: hit=%b data=%0d want 1/5", hit, data_out);
    end
  endtask

  task automatic test_async_reset;
    apply_reset();
    for (int i = 0; i < 4; i++)
      acc(1, 0, BASE + 32'(4 * i), 32'(100 + i));
    acc(0, 1, BASE + 32'h4, 32'h0);
    checks++;
    if (hit !== 1'b1 || data_out !== 32'd101) begin
      failures++;
      $display("FAIL pre_rst_read: hit=%b data=%0d want 1/101", hit, data_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (hit !== 1'b0 || data_out !== 32'h0) begin
      failures++;
      $display("FAIL async_rst: hit=%b data=%0d want 0/0", hit, data_out);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc(0, 1, BASE + 32'(4 * i), 32'h0);
      checks++;
      if (hit !== 1'b0 || data_out !== 32'h0) begin
        failures++;
        $display("FAIL post_rst_read[%0d]: hit=%b data=%0d want 0/0",
                 i, hit, data_out);
      end
    end
`ifdef FA_PERF_CNT_EN
    checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd4) begin
      failures++;
      $display("FAIL perf_cnt: hits=%0d misses=%0d want 0/4",
               hit_cnt, miss_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_evict();
    test_lru_order();
    test_write_hit();
    test_write_priority();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
